// File: rtl/fifo_reader_pkg.sv
// Shared types for the FIFO-to-stream reader: FSM state encoding and
// output-buffer sizing.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SKID_FULL = 2'd2;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer between FIFO pops and the downstream stream.
// Entry 0 is always the head word presented on dout/last_out.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 last_in,
  input  logic                 pop,
  output logic [1:0]           occupancy,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 last_out
);

  logic [DATAWIDTH-1:0] data0, data1;
  logic                 last0, last1;
  logic                 push_ok, pop_ok;

  // Guard against pushes into a full buffer or pops from an empty one.
  assign push_ok = push && (occupancy != SKID_FULL);
  assign pop_ok  = pop  && (occupancy != 2'd0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  // NOTE: the two storage entries are reset too, so dout reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= 2'd0;
      data0     <= '0;
      data1     <= '0;
      last0     <= 1'b0;
      last1     <= 1'b0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (occupancy == 2'd0) begin
            data0 <= din;
            last0 <= last_in;
          end else begin
            data1 <= din;
            last1 <= last_in;
          end
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          data0     <= data1;
          last0     <= last1;
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop keeps occupancy; only occupancy 1 is
          // reachable here because a full buffer refuses the push.
          data0 <= din;
          last0 <= last_in;
        end
        default: ;
      endcase
    end
  end

  assign dout     = data0;
  assign last_out = last0;

endmodule

// File: rtl/fifo_reader.sv
// Pops a requested number of words from a show-ahead FIFO and presents them
// as a valid/ready stream with last marking, a word count and a done pulse.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int COUNTWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATAWIDTH-1:0]  fifo_dout,
  output logic                  fifo_read,
  input  logic                  start,
  input  logic [COUNTWIDTH-1:0] len,
  output logic                  busy,
  output logic                  done,
  output logic                  m_valid,
  output logic [DATAWIDTH-1:0]  m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [COUNTWIDTH-1:0] count
);

  state_t                  state, state_next;
  logic [COUNTWIDTH-1:0]   remaining;
  logic [1:0]              occupancy;
  logic                    last_out;
  logic                    handshake;

  assign handshake = m_valid && m_ready;

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_next = state;
    fifo_read  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        // Occupancy is registered, so m_ready never reaches fifo_read.
        fifo_read = !reset && !fifo_empty && (remaining != '0) &&
                    (occupancy < SKID_FULL);
        if (fifo_read && remaining == COUNTWIDTH'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (occupancy == 2'd0 || (handshake && occupancy == 2'd1))
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      count     <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        remaining <= len;
        count     <= '0;
      end else begin
        if (fifo_read) remaining <= remaining - COUNTWIDTH'(1);
        if (handshake) count     <= count + COUNTWIDTH'(1);
      end
    end
  end

  fifo_reader_skid #(
    .DATAWIDTH(DATAWIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_read),
    .din       (fifo_dout),
    .last_in   (remaining == COUNTWIDTH'(1)),
    .pop       (handshake),
    .occupancy (occupancy),
    .dout      (m_data),
    .last_out  (last_out)
  );

  assign m_valid = (occupancy != 2'd0);
  assign m_last  = m_valid && last_out;
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);

endmodule
